// File: rtl/eth_frame_recorder.sv
// Captures one Ethernet frame (after the SFD) into a packet buffer, checks its CRC-32,
// then holds the frame and its status until software re-arms capture.
module eth_frame_recorder #(
    parameter int PACKET_BUFFER_SIZE = 2048,
    parameter int RAM_SIZE           = PACKET_BUFFER_SIZE,
    parameter int MAX_FRAME_LEN      = 1522,
    parameter int MIN_FRAME_LEN      = 64,
    localparam int ADDR_W            = $clog2(RAM_SIZE),
    localparam int LEN_W             = $clog2(MAX_FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_done,
    input  logic              arm,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [7:0]        ram_write_val,
    output logic              frame_ready,
    output logic [LEN_W-1:0]  frame_len,
    output logic              fcs_ok,
    output logic              runt,
    output logic              too_long
);

    if (MAX_FRAME_LEN > RAM_SIZE) begin : g_bad_size
        $error("eth_frame_recorder: MAX_FRAME_LEN must not exceed RAM_SIZE");
    end

    localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(MAX_FRAME_LEN);
    localparam logic [LEN_W-1:0] MIN_LEN     = LEN_W'(MIN_FRAME_LEN);
    localparam logic [7:0]       PREAMBLE    = 8'h55;
    localparam logic [7:0]       SFD         = 8'hD5;

    typedef enum logic [1:0] {
        HUNT,
        RECORD,
        DISCARD,
        HOLD
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [31:0]        crc_q, crc_d;
    logic               over_q, over_d;
    logic               wr_d;

    // Reflected CRC-32, one byte folded in LSB first, no final inversion.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    always_comb begin
        count_d = count_q;
        crc_d   = crc_q;
        over_d  = over_q;
        wr_d    = 1'b0;
        if (state_q == RECORD && in_valid) begin
            if (count_q < MAX_LEN) begin
                wr_d    = 1'b1;
                count_d = count_q + LEN_W'(1);
                crc_d   = crc_byte(crc_q, in_byte);
            end else begin
                over_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= HUNT;
            count_q          <= '0;
            crc_q            <= 32'hFFFF_FFFF;
            over_q           <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_write_addr   <= '0;
            ram_write_val    <= '0;
            frame_ready      <= 1'b0;
            frame_len        <= '0;
            fcs_ok           <= 1'b0;
            runt             <= 1'b0;
            too_long         <= 1'b0;
        end else begin
            ram_write_enable <= wr_d;
            if (wr_d) begin
                ram_write_addr <= ADDR_W'(count_q);
                ram_write_val  <= in_byte;
            end
            case (state_q)
                HUNT: begin
                    if (!in_done && in_valid) begin
                        if (in_byte == SFD) begin
                            state_q <= RECORD;
                            count_q <= '0;
                            crc_q   <= 32'hFFFF_FFFF;
                            over_q  <= 1'b0;
                        end else if (in_byte != PREAMBLE) begin
                            state_q <= DISCARD;
                        end
                    end
                end
                RECORD: begin
                    count_q <= count_d;
                    crc_q   <= crc_d;
                    over_q  <= over_d;
                    // A byte arriving with in_done is already folded into the _d values.
                    if (in_done) begin
                        state_q     <= HOLD;
                        frame_ready <= 1'b1;
                        frame_len   <= count_d;
                        fcs_ok      <= (crc_d == CRC_RESIDUE) && !over_d;
                        runt        <= (count_d < MIN_LEN);
                        too_long    <= over_d;
                    end
                end
                DISCARD: begin
                    if (in_done) begin
                        state_q <= HUNT;
                    end
                end
                HOLD: begin
                    if (arm) begin
                        state_q     <= HUNT;
                        frame_ready <= 1'b0;
                        frame_len   <= '0;
                        fcs_ok      <= 1'b0;
                        runt        <= 1'b0;
                        too_long    <= 1'b0;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_recorder.sv
// Directed bench for eth_frame_recorder: a frame-level model predicts buffer writes and
// held status, and a per-cycle compare process checks the DUT against it.
module tb_eth_frame_recorder;

    localparam int MAX_LEN = 1522;
    localparam int MIN_LEN = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inValid = 1'b0;
    logic [7:0]  inByte = 8'h00;
    logic        inDone = 1'b0;
    logic        armIn = 1'b0;
    logic        ramWe;
    logic [10:0] ramAddr;
    logic [7:0]  ramVal;
    logic        frameReady;
    logic [10:0] frameLen;
    logic        fcsOk;
    logic        runt;
    logic        tooLong;

    always #5 clk = ~clk;

    eth_frame_recorder dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (inValid),
        .in_byte         (inByte),
        .in_done         (inDone),
        .arm             (armIn),
        .ram_write_enable(ramWe),
        .ram_write_addr  (ramAddr),
        .ram_write_val   (ramVal),
        .frame_ready     (frameReady),
        .frame_len       (frameLen),
        .fcs_ok          (fcsOk),
        .runt            (runt),
        .too_long        (tooLong)
    );

    int         checks = 0;
    int         errors = 0;
    bit         checkEn = 1'b0;
    bit         holding = 1'b0;
    bit         expReady = 1'b0;
    int         expLen = 0;
    bit         expFcs = 1'b0;
    bit         expRunt = 1'b0;
    bit         expTooLong = 1'b0;
    int         writeCount = 0;
    int         lastWriteAddr = -1;
    int         expAddr[$];
    logic [7:0] expVal[$];
    logic [7:0] txQ[$];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Standard Ethernet CRC-32 (as a transmitter would compute the FCS) over txQ[start +: n].
    function automatic logic [31:0] crc32Of(input int start, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                if ((c[0] ^ txQ[start + k][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic buildPattern(input int n, input int seed);
        txQ.delete();
        repeat (7) txQ.push_back(8'h55);
        txQ.push_back(8'hD5);
        for (int i = 0; i < n; i++) txQ.push_back(8'(i * 37 + seed));
    endtask

    task automatic buildGood(input int seed);
        logic [31:0] fcs;
        buildPattern(60, seed);
        fcs = crc32Of(8, 60);
        for (int b = 0; b < 4; b++) txQ.push_back(fcs[8*b +: 8]);
    endtask

    task automatic driveCycle(input logic v, input logic [7:0] b, input logic d, input logic a);
        @(posedge clk);
        #1;
        inValid = v;
        inByte  = b;
        inDone  = d;
        armIn   = a;
    endtask

    // Sends txQ and updates the model: a frame is captured only when not holding and the
    // first non-0x55 byte is the SFD; bytes past MAX_LEN are counted but never written.
    task automatic applyStimulus(input bit doneWithLast);
        int          i;
        int          n;
        bit          captured;
        logic [31:0] fcsRx;
        i = 0;
        while (i < txQ.size() && txQ[i] == 8'h55) i++;
        captured = !holding && (i < txQ.size()) && (txQ[i] == 8'hD5);
        n = captured ? txQ.size() - i - 1 : 0;
        for (int k = 0; k < txQ.size(); k++) begin
            if (captured && k > i && (k - i - 1) < MAX_LEN) begin
                expAddr.push_back(k - i - 1);
                expVal.push_back(txQ[k]);
            end
            driveCycle(1'b1, txQ[k], doneWithLast && (k == txQ.size() - 1), 1'b0);
        end
        if (!doneWithLast) driveCycle(1'b0, 8'h00, 1'b1, 1'b0);
        driveCycle(1'b0, 8'h00, 1'b0, 1'b0);
        if (captured) begin
            expTooLong = (n > MAX_LEN);
            expLen     = expTooLong ? MAX_LEN : n;
            expRunt    = (expLen < MIN_LEN);
            if (n >= 4) fcsRx = {txQ[i + n], txQ[i + n - 1], txQ[i + n - 2], txQ[i + n - 3]};
            expFcs     = !expTooLong && (n >= 4) && (crc32Of(i + 1, n - 4) == fcsRx);
            holding    = 1'b1;
            expReady   = 1'b1;
        end
        driveCycle(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("writesDrained", expAddr.size(), 0);
    endtask

    task automatic doArm();
        driveCycle(1'b0, 8'h00, 1'b0, 1'b1);
        driveCycle(1'b0, 8'h00, 1'b0, 1'b0);
        if (holding) begin
            holding  = 1'b0;
            expReady = 1'b0;
        end
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        inValid = 1'b0;
        inDone  = 1'b0;
        armIn   = 1'b0;
        @(posedge clk);
        #1;
        holding  = 1'b0;
        expReady = 1'b0;
        repeat (cycles - 1) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("frameReady", frameReady, expReady);
            if (expReady) begin
                checkOutput("frameLen", frameLen, expLen);
                checkOutput("fcsOk", fcsOk, expFcs);
                checkOutput("runt", runt, expRunt);
                checkOutput("tooLong", tooLong, expTooLong);
            end
            if (ramWe === 1'b1) begin
                writeCount++;
                lastWriteAddr = int'(ramAddr);
                if (expAddr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedWrite: got write addr %0d val 0x%0h, expected no write at %0t",
                             ramAddr, ramVal, $time);
                end else begin
                    checkOutput("writeAddr", ramAddr, expAddr.pop_front());
                    checkOutput("writeVal", ramVal, expVal.pop_front());
                end
            end else begin
                checkOutput("writeEnable", ramWe, 0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetWe", ramWe, 0);
        checkOutput("resetAddr", ramAddr, 0);
        checkOutput("resetVal", ramVal, 0);
        checkOutput("resetReady", frameReady, 0);
        checkOutput("resetLen", frameLen, 0);
        checkOutput("resetFcs", fcsOk, 0);
        checkOutput("resetRunt", runt, 0);
        checkOutput("resetTooLong", tooLong, 0);
        reset   = 1'b1;
        checkEn = 1'b1;

        txQ = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        checkOutput("modelCrcPin", crc32Of(0, 9), 32'hCBF43926);

        $display("[TB] arm while hunting, then minimum-size good frame");
        doArm();
        buildGood(5);
        writeCount = 0;
        applyStimulus(1'b0);
        checkOutput("goodWrites", writeCount, 64);
        checkOutput("goodLastAddr", lastWriteAddr, 63);
        checkOutput("goodLen", frameLen, 64);
        checkOutput("goodFcs", fcsOk, 1);
        checkOutput("goodRunt", runt, 0);
        checkOutput("goodTooLong", tooLong, 0);

        $display("[TB] corrupted frame, then frame offered while holding");
        doArm();
        buildGood(5);
        txQ[18] = txQ[18] ^ 8'h04;
        applyStimulus(1'b0);
        checkOutput("badCrcLen", frameLen, 64);
        checkOutput("badCrcFcs", fcsOk, 0);
        buildGood(9);
        writeCount = 0;
        applyStimulus(1'b0);
        checkOutput("holdWrites", writeCount, 0);
        checkOutput("holdFcs", fcsOk, 0);
        doArm();
        buildGood(9);
        applyStimulus(1'b0);
        checkOutput("rearmFcs", fcsOk, 1);

        $display("[TB] broken preamble is discarded");
        doArm();
        txQ = '{8'h55, 8'h55, 8'h54, 8'h55, 8'hD5, 8'h10, 8'h20, 8'h30};
        writeCount = 0;
        applyStimulus(1'b0);
        checkOutput("discardWrites", writeCount, 0);
        checkOutput("discardReady", frameReady, 0);
        buildGood(77);
        applyStimulus(1'b0);
        checkOutput("afterDiscardFcs", fcsOk, 1);

        $display("[TB] oversize frame is truncated");
        doArm();
        buildPattern(1530, 3);
        writeCount = 0;
        applyStimulus(1'b0);
        checkOutput("longWrites", writeCount, 1522);
        checkOutput("longLastAddr", lastWriteAddr, 1521);
        checkOutput("longLen", frameLen, 1522);
        checkOutput("longTooLong", tooLong, 1);
        checkOutput("longFcs", fcsOk, 0);

        $display("[TB] runt frame with in_done on last byte");
        doArm();
        buildPattern(20, 11);
        writeCount = 0;
        applyStimulus(1'b1);
        checkOutput("runtWrites", writeCount, 20);
        checkOutput("runtLen", frameLen, 20);
        checkOutput("runtFlag", runt, 1);

        $display("[TB] reset in the middle of a frame");
        doArm();
        buildGood(21);
        writeCount = 0;
        for (int k = 0; k < 18; k++) begin
            if (k >= 8) begin
                expAddr.push_back(k - 8);
                expVal.push_back(txQ[k]);
            end
            driveCycle(1'b1, txQ[k], 1'b0, 1'b0);
        end
        doReset(2);
        driveCycle(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("abortWrites", writeCount, 10);
        checkOutput("abortReady", frameReady, 0);
        checkOutput("abortTooLong", tooLong, 0);
        buildGood(33);
        writeCount = 0;
        applyStimulus(1'b0);
        checkOutput("freshWrites", writeCount, 64);
        checkOutput("freshFcs", fcsOk, 1);

        driveCycle(1'b0, 8'h00, 1'b0, 1'b0);
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
